// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_pkg
// Brief    : Shared types and sizing helpers for the board-state RAM and its
//            sequential read-out engine.
// Revision : 1.0 - initial release
// ============================================================================
package board_pkg;

    // Defaults shared with the board-state RAM instance.
    localparam int c_DEFAULT_SIZE  = 8;
    localparam int c_DEFAULT_DEPTH = 8;

    // Scan engine states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Row-index width; a one-row RAM still needs a one-bit address.
    function automatic int row_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_scan_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : board_scan_reader_if
// Brief    : RAM read port plus row stream (valid/ready) between the scan
//            reader (master) and the RAM / display driver side (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface board_scan_reader_if
    import board_pkg::*;
#(
    parameter int SIZE  = c_DEFAULT_SIZE,
    parameter int DEPTH = c_DEFAULT_DEPTH
);
    localparam int c_ROW_W = row_w(DEPTH);

    logic [c_ROW_W-1:0] raddr;
    logic [SIZE-1:0]    read_data;
    logic [SIZE-1:0]    out_data;
    logic [c_ROW_W-1:0] out_row;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output raddr, out_data, out_row, out_valid,
        input  read_data, out_ready
    );

    modport slave (
        input  raddr, out_data, out_row, out_valid,
        output read_data, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo2
// Brief    : Two-entry registered FIFO. Entry 0 is always the oldest item and
//            drives the head outputs straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] r_entry0;
    logic [WIDTH-1:0] r_entry1;
    logic [1:0]       r_occ;

    // Shift-style storage: pops move entry 1 forward, pushes land in the first free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_occ    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_entry0 <= push_data;
                    else               r_entry1 <= push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_occ    <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= push_data;
                    end else begin
                        r_entry0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = r_entry0;
    assign head_valid = (r_occ != 2'd0);
    assign occ        = r_occ;

endmodule
`default_nettype wire

// File: rtl/board_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : board_scan_reader
// Brief    : Walks every row of the board-state RAM on a frame start, hides
//            the RAM's one-cycle read latency and streams {row, data} out
//            over valid/ready without losing throughput under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module board_scan_reader
    import board_pkg::*;
#(
    parameter int SIZE  = c_DEFAULT_SIZE,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    board_scan_reader_if.master bus
);
    localparam int                 c_ROW_W    = row_w(DEPTH);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(DEPTH - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_ROW_W-1:0]         r_issue;
    logic                       r_pend;
    logic [c_ROW_W-1:0]         r_pend_row;
    logic                       r_done;
    logic                       r_overrun;
    logic                       w_issue;
    logic                       w_last_pop;
    logic                       w_pop;
    logic                       w_out_valid;
    logic [1:0]                 w_occ;
    logic [2:0]                 w_inflight;
    logic [c_ROW_W+SIZE-1:0]    w_head;

    // Rows the buffer must still be able to hold once this cycle's pop retires.
    assign w_pop      = w_out_valid & bus.out_ready;
    assign w_inflight = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_pop};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state, read issue (credit check) and end-of-scan detection.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_last_pop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_inflight < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_issue == c_LAST_ROW) w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final row is leaving the buffer and nothing is in flight.
                if (!r_pend && (w_occ == 2'd1) && w_pop) begin
                    w_last_pop   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Issue counter; returns to 0 after the last row so raddr rests at 0 outside the scan.
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_IDLE) begin
            r_issue <= '0;
        end else if (w_issue) begin
            r_issue <= (r_issue == c_LAST_ROW) ? '0 : r_issue + c_ROW_W'(1);
        end
    end

    // Pending read tracking: tag the row whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_row <= '0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) r_pend_row <= r_issue;
        end
    end

    // Completion pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= w_last_pop;
            if (start && r_state != ST_IDLE) r_overrun <= 1'b1;
        end
    end

    skid_fifo2 #(
        .WIDTH (c_ROW_W + SIZE)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (r_pend),
        .push_data  ({r_pend_row, bus.read_data}),
        .pop        (w_pop),
        .head_data  (w_head),
        .head_valid (w_out_valid),
        .occ        (w_occ)
    );

    assign bus.raddr     = r_issue;
    assign bus.out_data  = w_head[SIZE-1:0];
    assign bus.out_row   = w_head[SIZE +: c_ROW_W];
    assign bus.out_valid = w_out_valid;
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_board_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_scan_reader
// Brief    : Self-checking bench: RAM model, scoreboard of expected rows and
//            timing expectations derived from the scan rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_scan_reader;
    import board_pkg::*;

    localparam int c_SIZE   = 8;
    localparam int c_DEPTH  = 8;
    localparam int c_DEPTH5 = 5;
    localparam int c_RW     = row_w(c_DEPTH);
    localparam int c_BUDGET = 200;

    logic clk = 1'b0;
    logic rst, start, busy, done, overrun;
    logic start5, busy5, done5, overrun5;
    logic [c_SIZE-1:0] mem8 [c_DEPTH];
    logic [c_SIZE-1:0] mem5 [c_DEPTH5];
    int n_checks = 0;
    int n_errors = 0;

    board_scan_reader_if #(.SIZE(c_SIZE), .DEPTH(c_DEPTH))  bus8 ();
    board_scan_reader_if #(.SIZE(c_SIZE), .DEPTH(c_DEPTH5)) bus5 ();

    board_scan_reader #(.SIZE(c_SIZE), .DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .overrun(overrun), .bus(bus8)
    );

    board_scan_reader #(.SIZE(c_SIZE), .DEPTH(c_DEPTH5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
        .overrun(overrun5), .bus(bus5)
    );

    always #5 clk = ~clk;

    // RAM models: one-cycle registered read.
    always @(posedge clk) begin
        bus8.read_data <= mem8[bus8.raddr];
        bus5.read_data <= mem5[bus5.raddr];
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // One scan of the DEPTH=8 instance. mode: 0 ready high, 1 stall window, 2 random ready.
    task automatic do_scan(input int mode, input int inject_at, input int rst_at,
                           input bit chain, input bit pre_started);
        int  exp_row = 0;
        int  max_out = 0;
        int  max_stall = 0;
        int  first_hs = -1;
        bit  raddr_bad = 0;
        bit  prev_stall = 0;
        bit  finished = 0;
        bit  ready;
        bit  nd;
        int  prev_row = 0;
        int  prev_data = 0;
        if (!pre_started) @(negedge clk);
        for (int c = 0; c < c_BUDGET && !finished; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == 0) || (c == inject_at);
            rst   = (c == rst_at);
            case (mode)
                0:       ready = 1'b1;
                1:       ready = !(c >= 4 && c <= 9);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus8.out_ready = ready;

            if (c == 1) begin
                check_eq("busy_after_start", 32'(busy), 1);
                check_eq("raddr_after_start", 32'(bus8.raddr), 0);
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                check_eq("rst_raddr", 32'(bus8.raddr), 0);
                check_eq("rst_out_data", 32'(bus8.out_data), 0);
                check_eq("rst_out_row", 32'(bus8.out_row), 0);
                check_eq("rst_out_valid", 32'(bus8.out_valid), 0);
                check_eq("rst_busy", 32'(busy), 0);
                check_eq("rst_done", 32'(done), 0);
                check_eq("rst_overrun", 32'(overrun), 0);
                nd = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (done) nd = 1;
                end
                check_eq("rst_no_done", 32'(nd), 0);
                return;
            end
            if (inject_at >= 0 && c == inject_at)     check_eq("overrun_before", 32'(overrun), 0);
            if (inject_at >= 0 && c == inject_at + 1) check_eq("overrun_set", 32'(overrun), 1);

            if (int'(bus8.raddr) > c_DEPTH - 1) raddr_bad = 1;
            if (busy && bus8.raddr != 0 && int'(bus8.raddr) - exp_row > max_out)
                max_out = int'(bus8.raddr) - exp_row;
            if (mode == 1 && c >= 4 && c <= 9 && int'(bus8.raddr) > max_stall)
                max_stall = int'(bus8.raddr);
            if (mode == 1 && c == 9) begin
                check_eq("stall_valid", 32'(bus8.out_valid), 1);
                check_eq("stall_row", 32'(bus8.out_row), 1);
            end
            if (prev_stall) begin
                check_eq("hold_valid", 32'(bus8.out_valid), 1);
                check_eq("hold_row", 32'(bus8.out_row), prev_row);
                check_eq("hold_data", 32'(bus8.out_data), prev_data);
            end

            if (c >= 2 && done) begin
                check_eq("done_rows", exp_row, c_DEPTH);
                check_eq("done_busy", 32'(busy), 0);
                check_eq("credit_limit", 32'(max_out <= 2), 1);
                check_eq("raddr_range", 32'(raddr_bad), 0);
                if (mode == 0 && inject_at < 0) begin
                    check_eq("done_cycle", c, c_DEPTH + 3);
                    check_eq("first_row_cycle", first_hs, 3);
                end
                if (mode == 1) check_eq("stall_raddr_max", max_stall, 3);
                if (inject_at >= 0) check_eq("overrun_sticky", 32'(overrun), 1);
                if (chain) start = 1'b1;
                finished = 1;
            end else begin
                if (bus8.out_valid && ready) begin
                    check_eq("row_order", 32'(bus8.out_row), exp_row);
                    check_eq("row_data", 32'(bus8.out_data), 32'(mem8[exp_row % c_DEPTH]));
                    if (first_hs < 0) first_hs = c;
                    exp_row++;
                end
                prev_stall = bus8.out_valid && !ready;
                prev_row   = 32'(bus8.out_row);
                prev_data  = 32'(bus8.out_data);
            end
        end
        if (!finished) check_eq("scan_timeout", 0, 1);
    endtask

    initial begin
        int  n5;
        int  max_raddr5;
        bit  d5_seen;
        rst = 1'b1;
        start = 1'b0;
        start5 = 1'b0;
        bus8.out_ready = 1'b1;
        bus5.out_ready = 1'b1;
        for (int i = 0; i < c_DEPTH; i++)  mem8[i] = 8'(8'hA0 + i);
        for (int i = 0; i < c_DEPTH5; i++) mem5[i] = 8'(8'h50 + 3 * i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_raddr", 32'(bus8.raddr), 0);
        check_eq("reset_out_data", 32'(bus8.out_data), 0);
        check_eq("reset_out_row", 32'(bus8.out_row), 0);
        check_eq("reset_out_valid", 32'(bus8.out_valid), 0);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_done", 32'(done), 0);
        check_eq("reset_overrun", 32'(overrun), 0);
        rst = 1'b0;

        do_scan(0, -1, -1, 1'b0, 1'b0);   // full throughput
        do_scan(1, -1, -1, 1'b0, 1'b0);   // backpressure window
        do_scan(0,  5, -1, 1'b1, 1'b0);   // start while busy, restart in done cycle
        do_scan(0, -1, -1, 1'b0, 1'b1);   // chained scan
        do_scan(0, -1,  6, 1'b0, 1'b0);   // reset mid-scan
        rst = 1'b0;
        do_scan(0, -1, -1, 1'b0, 1'b0);   // clean scan after reset

        for (int s = 0; s < 100; s++) begin
            for (int i = 0; i < c_DEPTH; i++) mem8[i] = 8'($urandom);
            do_scan(2, -1, -1, 1'b0, 1'b0);
        end
        bus8.out_ready = 1'b1;

        // DEPTH=5 instance: address range, row count, completion time.
        n5 = 0;
        max_raddr5 = 0;
        d5_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start5 = (c == 0);
            if (int'(bus5.raddr) > max_raddr5) max_raddr5 = int'(bus5.raddr);
            if (bus5.out_valid) begin
                check_eq("d5_row", 32'(bus5.out_row), n5);
                check_eq("d5_data", 32'(bus5.out_data), 32'(mem5[n5 % c_DEPTH5]));
                n5++;
            end
            if (c >= 2 && done5 && !d5_seen) begin
                check_eq("d5_done_cycle", c, c_DEPTH5 + 3);
                d5_seen = 1;
            end
        end
        check_eq("d5_raddr_max", max_raddr5, c_DEPTH5 - 1);
        check_eq("d5_rows", n5, c_DEPTH5);
        check_eq("d5_done_seen", 32'(d5_seen), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_scan_reader.md
# board_scan_reader

Sequential read-out engine placed directly downstream of the board-state dual-port RAM (1-cycle registered read). On a frame `start` pulse it walks every RAM row from address 0 to DEPTH-1, absorbs the RAM's one-cycle read latency, and delivers each row with its index to the display/feedback driver over a valid/ready handshake. A 2-entry output buffer with credit-based read issue preserves full throughput under arbitrary backpressure.

## Interface
- SIZE, 8: RAM word width; must match the RAM's SIZE.
- DEPTH, 8: rows to scan; must match the RAM's DEPTH; ≥2, power of two not required.
- clk  in  1  single clock; also drives RAM rclk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request.
- raddr  out  $clog2(DEPTH)  read address to RAM.
- read_data  in  SIZE  RAM read data; valid the cycle after raddr is sampled.
- out_data  out  SIZE  row contents.
- out_row  out  $clog2(DEPTH)  row index of out_data.
- out_valid  out  1  out_data/out_row valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan completes.
- overrun  out  1  sticky: start arrived while busy.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: raddr=0, no reads tracked. start → SCAN; issue counter cleared.
- SCAN: issue a read (raddr = issue count, pending flag set with row tag) when occ + pending − pop < 2; pop = out_valid & out_ready this cycle. After issuing row DEPTH-1 → DRAIN. raddr never exceeds DEPTH-1; no wrap.
- Pending read: next cycle read_data is written to the buffer tail with its row tag; pending clears unless a new read is issued that cycle.
- DRAIN: no new reads; when pending=0, occ=0 and last row handshaked → IDLE, done=1 for that cycle.
- Buffer: 2-entry FIFO, head drives out_data/out_row/out_valid from registers; push and pop in the same cycle allowed at any occupancy ≤2 where push would not exceed 2 after pop. Credit rule guarantees no overflow.
- Handshake: out_data/out_row held stable while out_valid & !out_ready; out_valid never drops without a handshake.
- start while busy (SCAN/DRAIN): ignored, overrun set; overrun cleared only by rst.
- start in the done cycle: accepted (state is IDLE).
- Row order strictly ascending 0..DEPTH-1, each row exactly once per scan.

## Timing
- Reset values: raddr=0, out_data=0, out_row=0, out_valid=0, busy=0, done=0, overrun=0; state IDLE, buffer empty, pending=0.
- rst mid-scan: all above restored next cycle; in-flight read discarded; no done.
- start sampled at edge of cycle S → busy=1 and raddr=0 in S+1; row 0 captured end of S+2; out_valid=1 in S+3.
- out_ready held high: rows 0..DEPTH-1 on consecutive cycles S+3..S+2+DEPTH; done and busy=0 in S+3+DEPTH. Total DEPTH+3 cycles start-to-done.
- out_ready low: at most 2 rows buffered, reads stall (raddr held); resumes throughput 1 row/cycle the cycle after ready returns.
- busy = state ≠ IDLE.

## Structure
- Shared package board_pkg: state encoding (IDLE/SCAN/DRAIN), row-index width function; SIZE/DEPTH defaults shared with the RAM instance.
- Sub-module skid_fifo2: 2-entry registered FIFO carrying {row, data}, with push/pop/occ ports. Issue counter, pending tracking and FSM stay in the top.

## Test plan
- DEPTH=8, RAM preloaded mem[i]=8'hA0+i, out_ready=1, start at S → rows 0..7 data A0..A7 on S+3..S+10, done at S+11, exactly 8 handshakes.
- Same preload, out_ready low S+4..S+9 → row 1 held stable with out_valid=1, raddr frozen ≤3, no lost/duplicated row, all 8 rows in order, done after last handshake.
- Random out_ready (50%) over 100 scans → scoreboard matches RAM contents, never >2 rows outstanding+buffered.
- start pulsed at S+5 during scan → ignored, overrun=1 and stays 1 after done; start in done cycle → new scan begins (busy next cycle).
- rst asserted at S+6 → next cycle all outputs 0, state IDLE, no done; fresh start yields full correct scan.
- DEPTH=5 → raddr sequence 0..4 only, 5 rows delivered, done at S+8.
